// File: rtl/phase_bank_pkg.sv
// Shared constants and FSM state type for the phase bank.
package phase_bank_pkg;

    localparam int unsigned NUM_CHANNELS = 128;
    localparam int unsigned CLK_CNT_W    = 8;
    localparam int unsigned CLK_CNT_MAX  = 249;
    localparam int unsigned CHAN_W       = $clog2(NUM_CHANNELS);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StWaitWrap
    } state_e;

endpackage

// File: rtl/phase_bank_if.sv
// Phase/calibration write handshakes plus commit control for the phase bank.
interface phase_bank_if #(
    parameter int unsigned CHAN_W = phase_bank_pkg::CHAN_W,
    parameter int unsigned DATA_W = phase_bank_pkg::CLK_CNT_W
);

    logic              wr_valid;
    logic              wr_ready;
    logic [CHAN_W-1:0] wr_chan;
    logic [DATA_W-1:0] wr_phase;
    logic              cal_valid;
    logic              cal_ready;
    logic [CHAN_W-1:0] cal_chan;
    logic [DATA_W-1:0] cal_value;
    logic              commit_req;
    logic              commit_ack;
    logic              busy;

    modport master (
        output wr_valid, wr_chan, wr_phase, cal_valid, cal_chan, cal_value, commit_req,
        input  wr_ready, cal_ready, commit_ack, busy
    );

    modport slave (
        input  wr_valid, wr_chan, wr_phase, cal_valid, cal_chan, cal_value, commit_req,
        output wr_ready, cal_ready, commit_ack, busy
    );

endinterface

// File: rtl/phase_wrap_add.sv
// Registered modular adder: sum = (a + b) mod (CLK_CNT_MAX + 1).
module phase_wrap_add #(
    parameter int unsigned CLK_CNT_W   = 8,
    parameter int unsigned CLK_CNT_MAX = 249
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CLK_CNT_W-1:0] a,
    input  logic [CLK_CNT_W-1:0] b,
    output logic [CLK_CNT_W-1:0] sum
);

    localparam logic [CLK_CNT_W:0] MaxExt = (CLK_CNT_W + 1)'(CLK_CNT_MAX);
    localparam logic [CLK_CNT_W:0] ModExt = (CLK_CNT_W + 1)'(CLK_CNT_MAX + 1);

    logic [CLK_CNT_W:0]   full;
    logic [CLK_CNT_W-1:0] sum_d;

    // One extra bit holds the carry; operands never exceed CLK_CNT_MAX.
    always_comb begin
        full  = {1'b0, a} + {1'b0, b};
        sum_d = (full > MaxExt) ? CLK_CNT_W'(full - ModExt) : CLK_CNT_W'(full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else begin
            sum <= sum_d;
        end
    end

endmodule

// File: rtl/phase_bank.sv
// Shadow/calibration phase bank; commits calibrated phases on a PWM counter wrap.
module phase_bank #(
    parameter int unsigned NUM_CHANNELS = phase_bank_pkg::NUM_CHANNELS,
    parameter int unsigned CLK_CNT_W    = phase_bank_pkg::CLK_CNT_W,
    parameter int unsigned CLK_CNT_MAX  = phase_bank_pkg::CLK_CNT_MAX
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [CLK_CNT_W-1:0]                    cnt,
    phase_bank_if.slave                             bus,
    output logic                                    range_err,
    output logic [NUM_CHANNELS-1:0][CLK_CNT_W-1:0]  phases_out
);

    import phase_bank_pkg::*;

    state_e               state_q;
    logic                 ack_q;
    logic                 err_q;
    logic [CLK_CNT_W-1:0] shadow_q [NUM_CHANNELS];
    logic [CLK_CNT_W-1:0] cal_q    [NUM_CHANNELS];
    logic [CLK_CNT_W-1:0] sum_q    [NUM_CHANNELS];
    logic                 wr_xfer;
    logic                 cal_xfer;
    logic                 wr_ok;
    logic                 cal_ok;

    assign bus.wr_ready   = (state_q == StIdle);
    assign bus.cal_ready  = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.commit_ack = ack_q;
    assign range_err      = err_q;

    assign wr_xfer  = bus.wr_valid && bus.wr_ready;
    assign cal_xfer = bus.cal_valid && bus.cal_ready;
    assign wr_ok    = (32'(bus.wr_phase) <= CLK_CNT_MAX) && (32'(bus.wr_chan) < NUM_CHANNELS);
    assign cal_ok   = (32'(bus.cal_value) <= CLK_CNT_MAX) && (32'(bus.cal_chan) < NUM_CHANNELS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                shadow_q[i] <= '0;
                cal_q[i]    <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wr_xfer) begin
                if (wr_ok) shadow_q[bus.wr_chan] <= bus.wr_phase;
                else       err_q <= 1'b1;
            end
            if (cal_xfer) begin
                if (cal_ok) cal_q[bus.cal_chan] <= bus.cal_value;
                else        err_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        phase_wrap_add #(
            .CLK_CNT_W  (CLK_CNT_W),
            .CLK_CNT_MAX(CLK_CNT_MAX)
        ) u_add (
            .clk  (clk),
            .rst_n(rst_n),
            .a    (shadow_q[g]),
            .b    (cal_q[g]),
            .sum  (sum_q[g])
        );
    end

    // ARM burns one cycle so the sum stage has absorbed any write accepted with the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ack_q      <= 1'b0;
            phases_out <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.commit_req) state_q <= StArm;
                end
                StArm: begin
                    state_q <= StWaitWrap;
                end
                StWaitWrap: begin
                    if (cnt == CLK_CNT_W'(CLK_CNT_MAX)) begin
                        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                            phases_out[i] <= sum_q[i];
                        end
                        ack_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_bank.sv
// Randomized + directed bench for phase_bank against a behavioural bank model.
module tb_phase_bank;

    import phase_bank_pkg::*;

    localparam int unsigned NCH  = NUM_CHANNELS;
    localparam int unsigned W    = CLK_CNT_W;
    localparam int unsigned MAXV = CLK_CNT_MAX;

    logic                        clk;
    logic                        rst_n;
    logic [W-1:0]                cnt;
    logic                        range_err;
    logic [NCH-1:0][W-1:0]       phases_out;

    phase_bank_if bus ();

    phase_bank u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt       (cnt),
        .bus       (bus),
        .range_err (range_err),
        .phases_out(phases_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model: bank contents, committed phases, and a pending-commit age.
    int m_shadow [NCH];
    int m_cal    [NCH];
    int m_phase  [NCH];
    bit m_busy, m_ack, m_err, m_wr_x, m_cal_x;
    int m_age;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_shadow[i] = 0;
            m_cal[i]    = 0;
            m_phase[i]  = 0;
        end
        m_busy = 0; m_ack = 0; m_err = 0; m_wr_x = 0; m_cal_x = 0; m_age = 0;
    endfunction

    // Called at each active edge with the inputs the DUT is sampling.
    function automatic void model_edge();
        bit ready;
        ready   = !m_busy;
        m_wr_x  = bus.wr_valid && ready;
        m_cal_x = bus.cal_valid && ready;
        m_ack   = 0;
        if (m_busy) begin
            m_age++;
            // A wrap seen on the edge right after the request is too early to commit.
            if (m_age >= 2 && int'(cnt) == MAXV) begin
                for (int i = 0; i < NCH; i++) m_phase[i] = (m_shadow[i] + m_cal[i]) % (MAXV + 1);
                m_ack  = 1;
                m_busy = 0;
            end
        end else if (bus.commit_req) begin
            m_busy = 1;
            m_age  = 0;
        end
        if (m_wr_x) begin
            if (int'(bus.wr_phase) > MAXV) m_err = 1;
            else m_shadow[bus.wr_chan] = int'(bus.wr_phase);
        end
        if (m_cal_x) begin
            if (int'(bus.cal_value) > MAXV) m_err = 1;
            else m_cal[bus.cal_chan] = int'(bus.cal_value);
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                int bad;
                check("commit_ack", bus.commit_ack, m_ack);
                check("busy", bus.busy, m_busy);
                check("wr_ready", bus.wr_ready, !m_busy);
                check("cal_ready", bus.cal_ready, !m_busy);
                check("range_err", range_err, m_err);
                bad = -1;
                for (int i = 0; i < NCH; i++) begin
                    if (bad < 0 && phases_out[i] !== W'(m_phase[i])) bad = i;
                end
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL phases_out[%0d] actual=%0d required=%0d",
                             bad, phases_out[bad], m_phase[bad]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (m_wr_x) bus.wr_valid = 1'b0;
        if (m_cal_x) bus.cal_valid = 1'b0;
        bus.commit_req = 1'b0;
        cnt = (int'(cnt) == MAXV) ? '0 : cnt + W'(1);
    endtask

    task automatic wr(input int ch, input int val);
        bus.wr_valid = 1'b1;
        bus.wr_chan  = CHAN_W'(ch);
        bus.wr_phase = W'(val);
        tick();
    endtask

    task automatic cal(input int ch, input int val);
        bus.cal_valid = 1'b1;
        bus.cal_chan  = CHAN_W'(ch);
        bus.cal_value = W'(val);
        tick();
    endtask

    task automatic commit_at(input int c);
        int guard;
        guard = 0;
        while (int'(cnt) != c && guard < 300) begin
            tick();
            guard++;
        end
        bus.commit_req = 1'b1;
        tick();
    endtask

    task automatic wait_ack(output int cycles, output int busy_low);
        cycles   = 0;
        busy_low = 0;
        do begin
            tick();
            cycles++;
            if (!bus.commit_ack && !bus.busy) busy_low++;
        end while (!bus.commit_ack && cycles < 600);
        if (!bus.commit_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=none required=commit_ack within 600 cycles");
        end
    endtask

    task automatic run(input int n, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.commit_ack) acks++;
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_phases_zero"}, (phases_out == '0), 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_ack"}, bus.commit_ack, 0);
        check({tag, "_err"}, range_err, 0);
        check({tag, "_wr_ready"}, bus.wr_ready, 1);
        check({tag, "_cal_ready"}, bus.cal_ready, 1);
    endtask

    task automatic do_reset();
        #2;
        rst_n          = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.cal_valid  = 1'b0;
        bus.commit_req = 1'b0;
        model_reset();
        #1;
        reset_checks("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc, blow, acks, nz;
        bus.wr_valid = 1'b0; bus.wr_chan = '0; bus.wr_phase = '0;
        bus.cal_valid = 1'b0; bus.cal_chan = '0; bus.cal_value = '0;
        bus.commit_req = 1'b0;
        cnt   = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        reset_checks("rst");

        // Basic commit, writes accepted on the first edge after reset.
        wr(3, 10);
        cal(3, 5);
        commit_at(100);
        wait_ack(cyc, blow);
        check("ack_latency_100", cyc, 149);
        check("ack_at_cnt0", cnt, 0);
        check("ch3_sum", phases_out[3], 15);
        nz = 0;
        for (int i = 0; i < NCH; i++) if (i != 3 && phases_out[i] != '0) nz++;
        check("others_zero", nz, 0);
        run(20, acks);
        check("ack_single", acks, 0);

        // (200 + 100) mod 250
        wr(7, 200);
        cal(7, 100);
        commit_at(0);
        wait_ack(cyc, blow);
        check("ch7_wrap", phases_out[7], 50);
        check("ch3_kept", phases_out[3], 15);

        // Request on the wrap cycle itself, and a wrap landing in ARM.
        commit_at(249);
        wait_ack(cyc, blow);
        check("late_req_latency", cyc, 250);
        check("busy_held", blow, 0);
        commit_at(248);
        wait_ack(cyc, blow);
        check("arm_wrap_skipped", cyc, 251);

        // Write and commit request while waiting for the wrap.
        commit_at(10);
        tick();
        tick();
        bus.wr_valid   = 1'b1;
        bus.wr_chan    = CHAN_W'(5);
        bus.wr_phase   = W'(77);
        bus.commit_req = 1'b1;
        check("wr_ready_while_busy", bus.wr_ready, 0);
        wait_ack(cyc, blow);
        check("ch5_not_in_commit", phases_out[5], 0);
        tick();
        check("req_in_wait_ignored", bus.busy, 0);
        run(5, acks);
        check("ch5_pending", phases_out[5], 0);
        commit_at(0);
        wait_ack(cyc, blow);
        check("ch5_next_commit", phases_out[5], 77);

        // Out-of-range write dropped; max-value wrap boundary.
        wr(0, 40);
        wr(0, 250);
        check("range_err_set", range_err, 1);
        wr(1, 249);
        cal(1, 249);
        commit_at(0);
        wait_ack(cyc, blow);
        check("ch0_kept", phases_out[0], 40);
        check("ch1_max_wrap", phases_out[1], 248);
        check("range_err_sticky", range_err, 1);

        // Reset while waiting for the wrap abandons the commit.
        commit_at(0);
        tick();
        tick();
        check("busy_in_wait", bus.busy, 1);
        do_reset();
        run(300, acks);
        check("no_ack_after_reset", acks, 0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            bus.wr_valid   = ($urandom_range(0, 1) == 1);
            bus.wr_chan    = CHAN_W'($urandom_range(0, NCH - 1));
            bus.wr_phase   = ($urandom_range(0, 31) == 0) ? W'($urandom_range(250, 255))
                                                          : W'($urandom_range(0, MAXV));
            bus.cal_valid  = ($urandom_range(0, 1) == 1);
            bus.cal_chan   = CHAN_W'($urandom_range(0, NCH - 1));
            bus.cal_value  = ($urandom_range(0, 63) == 0) ? W'($urandom_range(250, 255))
                                                          : W'($urandom_range(0, MAXV));
            bus.commit_req = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
